// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and defaults for the IF/MEM SRAM port arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef enum logic {FETCH, DATA} grant_t;
  localparam int SRAM_WAIT_DEF = 2;
  localparam int DM_BASE_DEF = 1024;
endpackage

// File: rtl/mem_arb_rr.sv
// mem_arb_rr: two-port round-robin grant with the last_grant flip-flop.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   req_if,
  input  logic   req_dm,
  input  logic   take,
  output grant_t grant,
  output logic   valid
);
  grant_t last_grant;
  assign valid = req_if | req_dm;
  // on contention the port that did not win last time gets the SRAM
  assign grant = (req_if && req_dm) ? ((last_grant == FETCH) ? DATA : FETCH)
                                    : (req_dm ? DATA : FETCH);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_grant <= FETCH;
    else if (take && valid) last_grant <= grant;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one multi-cycle SRAM between the fetch and data ports.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int SRAM_AW   = 16,
  parameter int SRAM_WAIT = SRAM_WAIT_DEF,
  parameter int DM_BASE   = DM_BASE_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_req,
  input  logic [31:0]        if_addr,
  output logic [DATA_W-1:0]  if_rdata,
  output logic               if_ready,
  input  logic               dm_rd,
  input  logic               dm_wr,
  input  logic [31:0]        dm_addr,
  input  logic [DATA_W-1:0]  dm_wdata,
  output logic [DATA_W-1:0]  dm_rdata,
  output logic               dm_ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [DATA_W-1:0]  sram_wdata,
  input  logic [DATA_W-1:0]  sram_rdata,
  output logic               sram_we_n,
  output logic               sram_oe_n
);
  state_t state_q, state_d;
  grant_t grant, port_q;
  logic req_any, wr_q, cnt_last;
  logic [3:0] cnt;
  logic [31:0] dm_off;
  logic unused_addr;
  assign dm_off = dm_addr - 32'(DM_BASE);
  assign unused_addr = ^{if_addr[31:SRAM_AW+2], if_addr[1:0], dm_off[31:SRAM_AW+2], dm_off[1:0]};
  assign cnt_last = cnt == 4'(SRAM_WAIT);
  mem_arb_rr u_rr (
    .clk   (clk),
    .rst   (rst),
    .req_if(if_req),
    .req_dm(dm_rd | dm_wr),
    .take  (state_q == IDLE),
    .grant (grant),
    .valid (req_any)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && req_any) state_d = ACCESS;
    if (state_q == ACCESS && cnt_last) state_d = DONE;
    if (state_q == DONE) state_d = IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      port_q <= FETCH;
      wr_q <= 1'b0;
      sram_addr <= '0;
      sram_wdata <= '0;
      sram_we_n <= 1'b1;
      sram_oe_n <= 1'b1;
      if_ready <= 1'b0;
      dm_ready <= 1'b0;
      if_rdata <= '0;
      dm_rdata <= '0;
    end else begin
      if_ready <= 1'b0;
      dm_ready <= 1'b0;
      if (state_q == IDLE && req_any) begin
        // a simultaneous rd+wr on the data port is treated as a write
        port_q <= grant;
        wr_q <= (grant == DATA) && dm_wr;
        sram_addr <= (grant == DATA) ? dm_off[SRAM_AW+1:2] : if_addr[SRAM_AW+1:2];
        if (grant == DATA) sram_wdata <= dm_wdata;
        cnt <= '0;
        sram_we_n <= !((grant == DATA) && dm_wr);
        sram_oe_n <= (grant == DATA) && dm_wr;
      end else if (state_q == ACCESS) begin
        cnt <= cnt + 4'd1;
        if (cnt_last) begin
          sram_we_n <= 1'b1;
          sram_oe_n <= 1'b1;
          if_ready <= port_q == FETCH;
          dm_ready <= port_q == DATA;
          if (!wr_q && port_q == FETCH) if_rdata <= sram_rdata;
          if (!wr_q && port_q == DATA) dm_rdata <= sram_rdata;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table plus reset/round-robin sequences, ready pulses scored against a queue.
module tb_mem_port_arbiter;
  localparam int W = 2;
  logic clk = 0, rst = 0;
  logic if_req = 0, dm_rd = 0, dm_wr = 0;
  logic [31:0] if_addr = 0, dm_addr = 0, dm_wdata = 0;
  logic [31:0] if_rdata, dm_rdata, sram_wdata, sram_rdata;
  logic if_ready, dm_ready, sram_we_n, sram_oe_n;
  logic [15:0] sram_addr;
  logic [31:0] mem [0:65535];
  int n_tests = 0, n_fail = 0, cyc = 0;

  typedef struct {
    logic is_data, rd, wr;
    logic [31:0] addr, wdata;
    logic [15:0] exp_addr;
    logic exp_we_n, exp_oe_n;
    logic [31:0] exp_rd;
  } vec_t;
  typedef struct {logic is_data; logic [31:0] rdata;} exp_t;
  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[9];
  logic [31:0] exp_if = 0, exp_dm = 0;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (!sram_we_n) mem[sram_addr] <= sram_wdata;
  assign sram_rdata = mem[sram_addr];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && (if_ready || dm_ready)) begin
      if (if_ready && dm_ready) chk("ready_overlap", {if_ready, dm_ready}, 64'b10);
      else if (sb.size() == 0) chk("unexpected_ready", {if_ready, dm_ready}, 64'b0);
      else begin
        mon_e = sb.pop_front();
        chk("ready_port", dm_ready, mon_e.is_data);
        chk("rdata", dm_ready ? dm_rdata : if_rdata, mon_e.rdata);
      end
    end
  end

  task automatic push_exp(input logic is_data, input logic rd, input logic wr, input logic [31:0] rdv);
    exp_t e;
    if (is_data && rd && !wr) exp_dm = rdv;
    if (!is_data) exp_if = rdv;
    e.is_data = is_data;
    e.rdata = is_data ? exp_dm : exp_if;
    sb.push_back(e);
  endtask

  task automatic check_reset_outputs(input string name);
    chk(name, {sram_addr, sram_wdata, sram_we_n, sram_oe_n, if_ready, dm_ready}, {16'h0, 32'h0, 4'b1100});
    chk({name, "_rdata"}, {if_rdata, dm_rdata}, 64'h0);
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    if (v.is_data) begin dm_rd = v.rd; dm_wr = v.wr; dm_addr = v.addr; dm_wdata = v.wdata; end
    else begin if_req = 1; if_addr = v.addr; end
    push_exp(v.is_data, v.rd, v.wr, v.exp_rd);
    @(posedge clk);
    for (int i = 0; i <= W; i++) begin
      @(negedge clk);
      chk("access", {sram_addr, sram_we_n, sram_oe_n, if_ready, dm_ready},
          {v.exp_addr, v.exp_we_n, v.exp_oe_n, 2'b00});
    end
    @(negedge clk);
    chk("latency", {if_ready, dm_ready, sram_we_n, sram_oe_n}, {!v.is_data, v.is_data, 2'b11});
    if (v.is_data && v.wr) chk("wdata", sram_wdata, v.wdata);
    if_req = 0; dm_rd = 0; dm_wr = 0;
  endtask

  initial begin
    int t[4];
    int n;
    bit got;
    mem[2] = 32'hE3A00001;
    mem[16'hFFFF] = 32'hDEADBEEF;
    //             is_d rd wr addr          wdata         exp_addr  we oe exp_rd
    vecs[0] = '{0, 0, 0, 32'h8,        32'h0,        16'h0002, 1, 0, 32'hE3A00001};
    vecs[1] = '{1, 0, 1, 32'd1028,     32'h12345678, 16'h0001, 0, 1, 32'h0};
    vecs[2] = '{1, 1, 0, 32'd1028,     32'h0,        16'h0001, 1, 0, 32'h12345678};
    vecs[3] = '{1, 1, 1, 32'd1032,     32'hAA,       16'h0002, 0, 1, 32'h0};
    vecs[4] = '{0, 0, 0, 32'h8,        32'h0,        16'h0002, 1, 0, 32'hAA};
    vecs[5] = '{1, 1, 0, 32'd1032,     32'h0,        16'h0002, 1, 0, 32'hAA};
    vecs[6] = '{1, 0, 1, 32'h0,        32'h5A5A5A5A, 16'hFF00, 0, 1, 32'h0};
    vecs[7] = '{0, 0, 0, 32'h0003FC00, 32'h0,        16'hFF00, 1, 0, 32'h5A5A5A5A};
    vecs[8] = '{0, 0, 0, 32'hFFFFFFFF, 32'h0,        16'hFFFF, 1, 0, 32'hDEADBEEF};

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if_req = 1'($urandom); dm_rd = 1'($urandom); dm_wr = 1'($urandom);
      if_addr = $urandom; dm_addr = $urandom; dm_wdata = $urandom;
      #1 check_reset_outputs("reset_hold");
    end
    @(negedge clk);
    if_req = 0; dm_rd = 0; dm_wr = 0;
    rst = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("idle_hold", {sram_addr, sram_we_n, sram_oe_n, if_ready, dm_ready}, {16'h0, 4'b1100});
    end

    foreach (vecs[i]) run_vec(vecs[i]);

    @(negedge clk);
    rst = 0;
    exp_if = 0; exp_dm = 0;
    if_req = 1; if_addr = 32'h8; dm_rd = 1; dm_addr = 32'd1028;
    @(negedge clk);
    rst = 1;
    for (int i = 0; i < 4; i++) push_exp(i % 2 == 0, 1, 0, (i % 2 == 0) ? 32'h12345678 : 32'hAA);
    n = 0;
    for (int k = 0; k < 40 && n < 4; k++) begin
      @(negedge clk);
      if (if_ready || dm_ready) begin t[n] = cyc; n++; end
    end
    if_req = 0; dm_rd = 0;
    chk("rr_count", n, 4);
    for (int i = 1; i < n; i++) chk("rr_spacing", t[i] - t[i-1], W + 3);

    @(negedge clk);
    @(negedge clk);
    dm_wr = 1; dm_addr = 32'd1036; dm_wdata = 32'h77;
    if_req = 1; if_addr = 32'h8;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("mid_write_we", sram_we_n, 1'b0);
    rst = 0;
    exp_if = 0; exp_dm = 0;
    #1 chk("async_we_n", sram_we_n, 1'b1);
    check_reset_outputs("mid_reset");
    dm_wr = 0;
    @(negedge clk);
    rst = 1;
    push_exp(0, 0, 0, 32'hAA);
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = if_ready;
    end
    chk("post_reset_fetch", got, 1'b1);
    if_req = 0;
    repeat (4) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
